// File: rtl/si_wb_stats_poller_pkg.sv
// Shared types and constants for the Wishbone statistics poller.
// Holds the sweep FSM state encoding and the timed-out word value.
package si_wb_poller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        OUT
    } state_t;

    localparam logic [31:0] TIMEOUT_WORD  = 32'hFFFF_FFFF;
    localparam int          WB_WORD_BYTES = 4;

endpackage

// File: rtl/si_wb_stats_poller_if.sv
// Bus bundle of the poller: Wishbone initiator side plus AXI-Stream output.
// master = poller, slave = Wishbone target together with the stream consumer.
interface si_wb_stats_poller_if;

    logic [7:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );

endinterface

// File: rtl/si_wb_stats_poller_timer.sv
// Auto-trigger down-counter: pulses fire once every POLL_PERIOD cycles.
// Ports: wb_clk, wb_rst (sync, active-high), fire (1-cycle pulse); POLL_PERIOD=0 never fires.
module si_wb_poll_timer #(
    parameter int unsigned POLL_PERIOD = 0
) (
    input  logic wb_clk,
    input  logic wb_rst,
    output logic fire
);

    localparam bit          ENABLE = (POLL_PERIOD != 0);
    localparam logic [31:0] RELOAD = ENABLE ? 32'(POLL_PERIOD - 1) : 32'd0;

    logic [31:0] cnt;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            cnt <= RELOAD;
        end else if (ENABLE) begin
            if (cnt == 32'd0) begin
                cnt <= RELOAD;
            end else begin
                cnt <= cnt - 32'd1;
            end
        end
    end

    assign fire = ENABLE && (cnt == 32'd0);

endmodule

// File: rtl/si_wb_stats_poller.sv
// Wishbone initiator sweeping NUM_REGS words from FIRST_ADDR into a framed AXI-Stream snapshot.
// Ports: wb_clk, wb_rst (sync high), start, busy, bus (Wishbone + stream), timeout_err, sweep_count.
module si_wb_stats_poller
    import si_wb_poller_pkg::*;
#(
    parameter int unsigned FIRST_ADDR     = 12,
    parameter int unsigned NUM_REGS       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned POLL_PERIOD    = 0
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic                  start,
    output logic                  busy,
    si_wb_stats_poller_if.master  bus,
    output logic                  timeout_err,
    output logic [31:0]           sweep_count
);

    localparam logic [5:0]  LAST_IDX = 6'(NUM_REGS - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  idx;
    logic [15:0] tmo_cnt;
    logic [31:0] data_q;
    logic [7:0]  adr_q;
    logic        pending;
    logic        poll_fire;
    logic        request;
    logic        go;
    logic        tmo_hit;
    logic        last;
    logic        hs;

    si_wb_poll_timer #(
        .POLL_PERIOD (POLL_PERIOD)
    ) u_timer (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .fire   (poll_fire)
    );

    // start and a poll expiry in the same cycle are one request
    assign request = start | poll_fire;
    assign go      = (state == IDLE) && (request || pending);
    assign last    = (idx == LAST_IDX);
    assign hs      = (state == OUT) && bus.m_axis_tready;
    // ack wins over a timeout landing in the same cycle
    assign tmo_hit = (state == WAIT) && !bus.wb_ack_i && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (request || pending) state_nxt = REQ;
            REQ:  state_nxt = WAIT;
            WAIT: if (bus.wb_ack_i || tmo_hit) state_nxt = OUT;
            OUT:  if (bus.m_axis_tready) state_nxt = last ? IDLE : REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state       <= IDLE;
            idx         <= '0;
            tmo_cnt     <= '0;
            data_q      <= '0;
            adr_q       <= '0;
            pending     <= 1'b0;
            timeout_err <= 1'b0;
            sweep_count <= '0;
        end else begin
            state <= state_nxt;
            if (go) begin
                idx <= '0;
            end
            if (state == REQ) begin
                adr_q   <= 8'(FIRST_ADDR + WB_WORD_BYTES * 32'(idx));
                tmo_cnt <= '0;
            end
            if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            // ack only counts in WAIT, so a trailing duplicate ack is ignored
            if ((state == WAIT) && bus.wb_ack_i) begin
                data_q <= bus.wb_dat_i;
            end else if (tmo_hit) begin
                data_q      <= TIMEOUT_WORD;
                timeout_err <= 1'b1;
            end
            if (hs && !last) begin
                idx <= idx + 6'd1;
            end
            if (hs && last) begin
                sweep_count <= sweep_count + 32'd1;
            end
            // one level of queued request; IDLE consumes it
            if (state == IDLE) begin
                pending <= 1'b0;
            end else if (request) begin
                pending <= 1'b1;
            end
        end
    end

    assign busy              = (state != IDLE);
    assign bus.wb_adr_o      = adr_q;
    assign bus.wb_dat_o      = '0;
    assign bus.wb_we_o       = 1'b0;
    assign bus.wb_stb_o      = (state == WAIT);
    assign bus.wb_cyc_o      = (state == WAIT);
    assign bus.m_axis_tdata  = data_q;
    assign bus.m_axis_tvalid = (state == OUT);
    assign bus.m_axis_tlast  = (state == OUT) && last;

endmodule

// File: tb/tb_si_wb_stats_poller.sv
// Bench for si_wb_stats_poller: frame/queue reference model plus directed scenarios.
// dut0 runs start-driven with a short timeout; dut1 runs on the poll timer alone.
module tb_si_wb_stats_poller;

    localparam int FIRST = 12;
    localparam int N     = 8;
    localparam int TMO   = 10;
    localparam int PER   = 100;

    logic wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    logic        rst0;
    logic        start0;
    logic        busy0;
    logic        terr0;
    logic [31:0] cnt0;
    logic        rst1;
    logic        start1;
    logic        busy1;
    logic        terr1;
    logic [31:0] cnt1;

    si_wb_stats_poller_if b0 ();
    si_wb_stats_poller_if b1 ();

    si_wb_stats_poller #(
        .FIRST_ADDR(FIRST), .NUM_REGS(N), .TIMEOUT_CYCLES(TMO), .POLL_PERIOD(0)
    ) dut0 (
        .wb_clk(wb_clk), .wb_rst(rst0), .start(start0), .busy(busy0),
        .bus(b0), .timeout_err(terr0), .sweep_count(cnt0)
    );

    si_wb_stats_poller #(
        .FIRST_ADDR(FIRST), .NUM_REGS(N), .TIMEOUT_CYCLES(255), .POLL_PERIOD(PER)
    ) dut1 (
        .wb_clk(wb_clk), .wb_rst(rst1), .start(start1), .busy(busy1),
        .bus(b1), .timeout_err(terr1), .sweep_count(cnt1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave 0: random wait states, duplicate ack carries junk
    logic [7:0] dead_addr = 8'hFF;
    int         max_wait  = 0;
    int         wcnt      = 0;

    always @(posedge wb_clk) begin
        if (rst0) begin
            b0.wb_ack_i <= 1'b0;
            b0.wb_dat_i <= 32'h0;
            wcnt        <= 0;
        end else if (b0.wb_stb_o && b0.wb_adr_o != dead_addr && wcnt == 0) begin
            b0.wb_ack_i <= 1'b1;
            b0.wb_dat_i <= b0.wb_ack_i ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(b0.wb_adr_o);
            wcnt        <= $urandom_range(max_wait, 0);
        end else begin
            b0.wb_ack_i <= 1'b0;
            b0.wb_dat_i <= 32'h5555_5555;
            if (b0.wb_stb_o && wcnt != 0) wcnt <= wcnt - 1;
        end
    end

    // ---------------- slave 1: plain registered ack
    always @(posedge wb_clk) begin
        if (rst1) begin
            b1.wb_ack_i <= 1'b0;
            b1.wb_dat_i <= 32'h0;
        end else begin
            b1.wb_ack_i <= b1.wb_stb_o && !b1.wb_ack_i;
            b1.wb_dat_i <= 32'hA000_0000 + 32'(b1.wb_adr_o);
        end
    end

    // ---------------- reference model for dut0
    typedef struct {
        logic [31:0] d;
        logic        l;
    } word_t;

    word_t       exp_w[$];
    logic [7:0]  exp_a[$];
    bit          m_active;
    bit          m_pending;
    bit          m_merge;
    bit          m_terr;
    int          m_done;
    int          hs_count;
    bit          after_rst;
    bit          prev_stb;
    bit          prev_stall;
    logic [7:0]  prev_adr  = 8'h0;
    logic [31:0] prev_data = 32'h0;
    logic        prev_last = 1'b0;
    int          stb_run;

    function automatic void push_frame();
        for (int i = 0; i < N; i++) begin
            logic [7:0] a;
            word_t w;
            a = 8'(FIRST + 4 * i);
            w.d = (a == dead_addr) ? 32'hFFFF_FFFF : 32'hA000_0000 + 32'(a);
            w.l = (i == N - 1);
            exp_a.push_back(a);
            exp_w.push_back(w);
        end
    endfunction

    function automatic void request();
        if (m_merge) return;
        if (!m_active) begin
            m_active = 1'b1;
            push_frame();
        end else if (!m_pending) begin
            m_pending = 1'b1;
        end
    endfunction

    always @(negedge wb_clk) begin
        word_t w;
        if (after_rst) begin
            check("rst_busy", busy0, 0);
            check("rst_stb", b0.wb_stb_o, 0);
            check("rst_tvalid", b0.m_axis_tvalid, 0);
            check("rst_count", cnt0, 0);
            check("rst_terr", terr0, 0);
            after_rst = 1'b0;
        end
        check("sweep_count", cnt0, 32'(m_done));
        check("cyc_eq_stb", b0.wb_cyc_o, b0.wb_stb_o);
        if (prev_stb && !b0.wb_stb_o) begin
            if (prev_adr == dead_addr) begin
                check("stb_len", 32'(stb_run), TMO);
                m_terr = 1'b1;
            end
            stb_run = 0;
        end
        if (b0.wb_stb_o) begin
            if (!prev_stb) begin
                check("wb_cycle_expected", exp_a.size() > 0, 1);
                if (exp_a.size() > 0) check("adr", b0.wb_adr_o, exp_a.pop_front());
            end else begin
                check("adr_hold", b0.wb_adr_o, prev_adr);
            end
            stb_run++;
        end
        check("timeout_err", terr0, m_terr);
        if (b0.m_axis_tvalid) check("no_wb_in_out", b0.wb_stb_o, 0);
        if (prev_stall) begin
            check("hold_valid", b0.m_axis_tvalid, 1);
            check("hold_data", b0.m_axis_tdata, prev_data);
            check("hold_last", b0.m_axis_tlast, prev_last);
        end
        prev_stb   = b0.wb_stb_o;
        prev_adr   = b0.wb_adr_o;
        prev_stall = b0.m_axis_tvalid && !b0.m_axis_tready;
        prev_data  = b0.m_axis_tdata;
        prev_last  = b0.m_axis_tlast;
        if (rst0) begin
            exp_w.delete();
            exp_a.delete();
            m_active   = 1'b0;
            m_pending  = 1'b0;
            m_merge    = 1'b0;
            m_terr     = 1'b0;
            m_done     = 0;
            prev_stb   = 1'b0;
            prev_stall = 1'b0;
            stb_run    = 0;
            after_rst  = 1'b1;
        end else begin
            if (start0) request();
            m_merge = 1'b0;
            if (b0.m_axis_tvalid && b0.m_axis_tready) begin
                hs_count++;
                check("word_expected", exp_w.size() > 0, 1);
                if (exp_w.size() > 0) begin
                    w = exp_w.pop_front();
                    check("tdata", b0.m_axis_tdata, w.d);
                    check("tlast", b0.m_axis_tlast, w.l);
                    if (w.l) begin
                        m_done++;
                        m_active = 1'b0;
                        if (m_pending) begin
                            m_pending = 1'b0;
                            m_active  = 1'b1;
                            m_merge   = 1'b1;
                            push_frame();
                        end
                    end
                end
            end
        end
    end

    // ---------------- dut1: poll-timer only
    bit done1 = 1'b0;

    initial begin
        int rises[$];
        bit pb = 1'b0;
        rst1 = 1'b1;
        start1 = 1'b0;
        b1.m_axis_tready = 1'b1;
        repeat (3) @(posedge wb_clk);
        #1 rst1 = 1'b0;
        for (int k = 1; k <= 620; k++) begin
            @(negedge wb_clk);
            if (busy1 && !pb) rises.push_back(k);
            pb = busy1;
            if (b1.m_axis_tvalid && b1.m_axis_tlast)
                check("poll_last_word", b1.m_axis_tdata, 32'hA000_0028);
            if (k == 560) check("poll_count_5", cnt1, 5);
        end
        check("poll_frames", rises.size(), 6);
        if (rises.size() > 0) check("poll_first", rises[0], PER + 1);
        for (int i = 1; i < rises.size(); i++)
            check("poll_interval", rises[i] - rises[i-1], PER);
        check("poll_terr", terr1, 0);
        done1 = 1'b1;
    end

    // ---------------- dut0 stimulus
    task automatic pulse_start0();
        @(posedge wb_clk);
        #1 start0 = 1'b1;
        @(posedge wb_clk);
        #1 start0 = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(posedge wb_clk);
        #1;
        while ((busy0 || exp_w.size() != 0) && n < 2000) begin
            @(posedge wb_clk);
            #1;
            n++;
        end
        check(name, n < 2000, 1);
    endtask

    initial begin
        int n;
        int s;
        rst0 = 1'b1;
        start0 = 1'b0;
        b0.m_axis_tready = 1'b1;
        repeat (3) @(posedge wb_clk);
        #1 rst0 = 1'b0;
        @(negedge wb_clk);
        check("reset_busy", busy0, 0);
        check("reset_stb", b0.wb_stb_o, 0);
        check("reset_we", b0.wb_we_o, 0);
        check("reset_dat_o", b0.wb_dat_o, 0);
        check("reset_adr", b0.wb_adr_o, 0);
        check("reset_tvalid", b0.m_axis_tvalid, 0);
        check("reset_tdata", b0.m_axis_tdata, 0);
        check("reset_count", cnt0, 0);

        // zero-wait sweep, latency and frame shape
        max_wait = 0;
        pulse_start0();
        n = 0;
        @(negedge wb_clk);
        check("busy_after_start", busy0, 1);
        while (!b0.m_axis_tvalid && n < 20) begin
            @(negedge wb_clk);
            n++;
        end
        check("busy_to_tvalid", n, 3);
        check("word0", b0.m_axis_tdata, 32'hA000_000C);
        check("word0_not_last", b0.m_axis_tlast, 0);
        n = 0;
        while (!(b0.m_axis_tvalid && b0.m_axis_tlast) && n < 100) begin
            @(negedge wb_clk);
            n++;
        end
        check("frame_cycles", n, 28);
        check("word7", b0.m_axis_tdata, 32'hA000_0028);
        wait_idle("idle_1");
        check("count_1", cnt0, 1);

        // backpressure on word 3
        s = hs_count;
        pulse_start0();
        n = 0;
        while (hs_count < s + 3 && n < 200) begin
            @(posedge wb_clk);
            #1;
            n++;
        end
        b0.m_axis_tready = 1'b0;
        n = 0;
        while (!b0.m_axis_tvalid && n < 50) begin
            @(posedge wb_clk);
            #1;
            n++;
        end
        check("stall_reached", b0.m_axis_tvalid, 1);
        repeat (20) @(posedge wb_clk);
        #1;
        check("stall_word3", b0.m_axis_tdata, 32'hA000_0018);
        check("stall_no_wb", b0.wb_stb_o, 0);
        b0.m_axis_tready = 1'b1;
        wait_idle("idle_2");
        check("count_2", cnt0, 2);

        // slave never acks address 20
        dead_addr = 8'd20;
        pulse_start0();
        wait_idle("idle_3");
        check("timeout_set", terr0, 1);
        check("count_3", cnt0, 3);
        dead_addr = 8'hFF;

        // four starts during one sweep give two frames
        pulse_start0();
        repeat (5) @(posedge wb_clk);
        pulse_start0();
        repeat (5) @(posedge wb_clk);
        pulse_start0();
        repeat (5) @(posedge wb_clk);
        pulse_start0();
        wait_idle("idle_4");
        check("count_5", cnt0, 5);

        // random starts, backpressure and wait states
        max_wait = 3;
        for (int i = 0; i < 3000; i++) begin
            @(posedge wb_clk);
            #1;
            b0.m_axis_tready = ($urandom_range(3, 0) != 0);
            start0 = ($urandom_range(39, 0) == 0);
        end
        start0 = 1'b0;
        b0.m_axis_tready = 1'b1;
        wait_idle("idle_rand");

        // reset during word 4
        max_wait = 0;
        pulse_start0();
        n = 0;
        while (!(b0.wb_stb_o && b0.wb_adr_o == 8'd28) && n < 200) begin
            @(posedge wb_clk);
            #1;
            n++;
        end
        check("reached_word4", b0.wb_stb_o, 1);
        rst0 = 1'b1;
        @(posedge wb_clk);
        #1 rst0 = 1'b0;
        check("midrst_busy", busy0, 0);
        check("midrst_stb", b0.wb_stb_o, 0);
        check("midrst_tvalid", b0.m_axis_tvalid, 0);
        check("midrst_count", cnt0, 0);
        pulse_start0();
        wait_idle("idle_6");
        check("clean_count", cnt0, 1);
        check("clean_terr", terr0, 0);

        n = 0;
        while (!done1 && n < 2000) begin
            @(posedge wb_clk);
            n++;
        end
        check("poll_bench_done", done1, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
